fetch_align_buffer: RTL and testbench
=====================================

// Module: fetch_align_buffer
// PURPOSE
//  Halfword-granular fetch/realignment queue between the I-cache port and the RVC
//  decompress/IF register. Owns the fetch word address and accepts 32-bit words.
//  Emits one complete instruction per handshake (16- or 32-bit), including 32-bit
//  instructions straddling a word boundary, with the instruction PC.
// PARAMETERS
//  HW_DEPTH  4  queue capacity in 16-bit halfwords (even, >=4)
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   synchronous active-low reset
//  redirect     in   1   flush queue, restart fetch at redirect_pc (branch/jump/flush)
//  redirect_pc  in   32  new PC; bit0 ignored
//  fetch_addr   out  30  word address presented to I-cache
//  fetch_en     out  1   read enable; high when queue has room for 2 halfwords
//  fetch_stall  in   1   I-cache not ready; fetch_data invalid this cycle
//  fetch_data   in   32  word at fetch_addr, big-endian byte order
//  out_valid    out  1   head instruction complete
//  out_ready    in   1   consumer accepts head instruction
//  out_inst     out  32  {16'b0,hw} if RVC else {hw1,hw0}
//  out_pc       out  32  PC of head instruction
//  out_is_rvc   out  1   head is 16-bit (hw0[1:0]!=2'b11)
// BEHAVIOUR
//  - Byte swap: le={d[7:0],d[15:8],d[23:16],d[31:24]}; le[15:0] is the lower address.
//  - Word accept: fetch_en & !fetch_stall & !redirect -> push le[15:0] (unless drop_low),
//    then le[31:16]; fetch_addr+1 next cycle (wraps at 2^30). drop_low cleared on accept.
//  - fetch_en = (count <= HW_DEPTH-2), from registered count; no same-cycle pop credit.
//  - Head decode: hw0[1:0]!=2'b11 -> RVC, needs 1 halfword; else needs 2.
//  - out_valid = count>=need. Straddling 32-bit with count==1 -> out_valid=0 until next word.
//  - Pop: out_valid & out_ready -> drop 1 or 2 halfwords, out_pc += 2 or 4.
//  - Push and pop in same cycle legal; count updates by push-pop.
//  - hw0==16'h0000 is a 16-bit instruction (c.illegal); passed through, not filtered.
//  - Redirect (priority over push/pop): count<=0, fetch_addr<=redirect_pc[31:2],
//    out_pc<={redirect_pc[31:1],1'b0}, drop_low<=redirect_pc[1]; no word accepted,
//    no pop that cycle. out_valid=0 the following cycle.
//  - Stall: fetch_stall holds fetch_addr and queue; output side continues draining.
//  - Reset: count=0, storage=0, fetch_addr=0, out_pc=0, drop_low=0 -> out_valid=0,
//    out_inst=0, out_is_rvc=1, fetch_en=1. Reset mid-stream discards all state.
//  - Overflow impossible by fetch_en rule; underflow impossible by out_valid rule.
// CONFIGURATION
//  RVC_ALIGN_EN defined: behaviour above.
//  Undefined: word-only path; each accepted word is one instruction, out_is_rvc=0,
//    redirect_pc[1:0] ignored, drop_low absent, out_pc += 4; queue holds HW_DEPTH/2 words.
// STRUCTURE
//  Package riscv_fetch_pkg: NOP_INST=32'h00000013, halfword_t (16b), is_rvc(hw) function,
//    byte-swap function.
//  Sub-module align_hw_queue: circular halfword storage, rd/wr pointers, count,
//    push 0/1/2, pop 0/1/2, peek hw0/hw1. Top holds fetch_addr, out_pc, drop_low, decode.
// TESTING
//  1. Reset, data 0x13000000 (le 0x00000013), stall=0, ready=1 -> out_inst 0x00000013,
//     out_pc 0,4,8...; fetch_addr 0,1,2.
//  2. Word le 0x45014501 (two c.li) -> two pops, out_is_rvc=1, inst 0x4501, pc 0 then 2.
//  3. Straddle: le words 0x00134501, then 0x????0000 -> RVC @0, then 0x00000013 @2 only
//     after 2nd word accepted; out_valid=0 in between.
//  4. redirect_pc 0x102 with queue full -> next accept drops low half, first out_pc 0x102,
//     fetch_addr 0x40.
//  5. out_ready=0 for 10 cycles -> fetch_en drops when count>HW_DEPTH-2, no data loss;
//     release -> in-order sequence.
//  6. Random fetch_stall + out_ready, redirect same cycle as push and pop -> redirect wins,
//     scoreboard vs reference PC/instruction model.

Source files
------------

// File: rtl/riscv_fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : riscv_fetch_pkg                                                  |
// | Purpose : Shared types and helpers for the fetch/realignment path.         |
// |           NOP_INST  - canonical addi x0,x0,0 encoding                      |
// |           halfword_t- one 16-bit instruction parcel                        |
// |           is_rvc    - parcel starts a compressed (16-bit) instruction      |
// |           bswap32   - cache word (big-endian) to little-endian parcels     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package riscv_fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef logic [15:0] halfword_t;

  // Low two opcode bits other than 2'b11 mark a 16-bit instruction.
  function automatic logic is_rvc(input halfword_t hw);
    return (hw[1:0] != 2'b11);
  endfunction

  // After the swap, bits [15:0] hold the parcel at the lower address.
  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/align_hw_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : align_hw_queue                                                   |
// | Purpose : Circular halfword queue; pushes and pops 0, 1 or 2 parcels per   |
// |           cycle and exposes the two oldest parcels for decode.             |
// | Ports   : clk, rst_n (sync, active-low), flush_i (empty the queue),        |
// |           push_n_i/push_hw0_i/push_hw1_i (hw0 written first),              |
// |           pop_n_i, peek_hw0_o/peek_hw1_o (oldest, next), count_o           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module align_hw_queue
  import riscv_fetch_pkg::*;
#(
  parameter int HW_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush_i,
  input  logic [1:0]                    push_n_i,
  input  halfword_t                     push_hw0_i,
  input  halfword_t                     push_hw1_i,
  input  logic [1:0]                    pop_n_i,
  output halfword_t                     peek_hw0_o,
  output halfword_t                     peek_hw1_o,
  output logic [$clog2(HW_DEPTH+1)-1:0] count_o
);

  localparam int c_PW = $clog2(HW_DEPTH);
  localparam int c_CW = $clog2(HW_DEPTH + 1);

  halfword_t         mem_q [HW_DEPTH];
  logic [c_PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [c_PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [c_CW-1:0]   count_q, count_d;
  logic [c_PW-1:0]   w_wr_ptr_p1;

  // Modulo add so that depths which are not a power of two still wrap.
  function automatic logic [c_PW-1:0] ptr_add(input logic [c_PW-1:0] p, input logic [1:0] n);
    logic [c_PW:0] s;
    s = {1'b0, p} + {{(c_PW-1){1'b0}}, n};
    if (s >= (c_PW+1)'(HW_DEPTH)) begin
      s = s - (c_PW+1)'(HW_DEPTH);
    end
    return s[c_PW-1:0];
  endfunction

  assign w_wr_ptr_p1 = ptr_add(wr_ptr_q, 2'd1);

  always_comb begin
    rd_ptr_d = ptr_add(rd_ptr_q, pop_n_i);
    wr_ptr_d = ptr_add(wr_ptr_q, push_n_i);
    count_d  = count_q + c_CW'(push_n_i) - c_CW'(pop_n_i);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < HW_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (!flush_i && (push_n_i != 2'd0)) begin
        mem_q[wr_ptr_q] <= push_hw0_i;
      end
      if (!flush_i && (push_n_i == 2'd2)) begin
        mem_q[w_wr_ptr_p1] <= push_hw1_i;
      end
    end
  end

  assign peek_hw0_o = mem_q[rd_ptr_q];
  assign peek_hw1_o = mem_q[ptr_add(rd_ptr_q, 2'd1)];
  assign count_o    = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_align_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fetch_align_buffer                                               |
// | Purpose : Fetch/realignment queue between the I-cache and the decompress   |
// |           stage. Owns the fetch word address, queues 16-bit parcels and    |
// |           presents one complete instruction (16 or 32 bit) with its PC.    |
// | Config  : RVC_ALIGN_EN defined -> compressed-aware halfword alignment;     |
// |           undefined -> every accepted word is one 32-bit instruction.      |
// | Ports   : clk, rst_n (sync, active-low); redirect/redirect_pc (flush and   |
// |           restart); fetch_addr/fetch_en/fetch_stall/fetch_data (cache);    |
// |           out_valid/out_ready/out_inst/out_pc/out_is_rvc (consumer)        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module fetch_align_buffer
  import riscv_fetch_pkg::*;
#(
  parameter int HW_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [29:0] fetch_addr,
  output logic        fetch_en,
  input  logic        fetch_stall,
  input  logic [31:0] fetch_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_is_rvc
);

  localparam int              c_CW        = $clog2(HW_DEPTH + 1);
  localparam logic [c_CW-1:0] c_FETCH_LIM = c_CW'(HW_DEPTH - 2);

  logic [29:0]     fetch_addr_q, fetch_addr_d;
  logic [31:0]     out_pc_q, out_pc_d;
  logic [c_CW-1:0] w_count;
  logic [c_CW-1:0] w_need;
  halfword_t       w_hw0, w_hw1;
  halfword_t       w_push_hw0, w_push_hw1;
  logic [1:0]      w_push_n, w_pop_n;
  logic [31:0]     w_le;
  logic            w_head_rvc;
  logic            w_accept, w_pop;
  logic            w_unused_rpc;

  // Bit 0 of the redirect target is never meaningful; bit 1 only matters
  // when compressed alignment is built in.
  assign w_unused_rpc = ^redirect_pc[1:0];

  assign w_le     = bswap32(fetch_data);
  // Room check uses the registered count only: a pop in the same cycle does
  // not create room, which keeps this path off the consumer's ready.
  assign fetch_en = (w_count <= c_FETCH_LIM);
  assign w_accept = fetch_en & ~fetch_stall & ~redirect;

`ifdef RVC_ALIGN_EN
  logic drop_low_q, drop_low_d;
  assign w_head_rvc = is_rvc(w_hw0);
`else
  assign w_head_rvc = 1'b0;
`endif

  assign w_need    = w_head_rvc ? c_CW'(1) : c_CW'(2);
  assign out_valid = (w_count >= w_need);
  assign w_pop     = out_valid & out_ready & ~redirect;

  always_comb begin
    w_push_n     = 2'd0;
    w_push_hw0   = w_le[15:0];
    w_push_hw1   = w_le[31:16];
    w_pop_n      = 2'd0;
    fetch_addr_d = fetch_addr_q;
    out_pc_d     = out_pc_q;
`ifdef RVC_ALIGN_EN
    drop_low_d   = drop_low_q;
`endif

    if (w_accept) begin
      w_push_n     = 2'd2;
      fetch_addr_d = fetch_addr_q + 30'd1;
`ifdef RVC_ALIGN_EN
      // Entry into the upper half of a word: skip the lower parcel once.
      if (drop_low_q) begin
        w_push_n   = 2'd1;
        w_push_hw0 = w_le[31:16];
      end
      drop_low_d = 1'b0;
`endif
    end

    if (w_pop) begin
      w_pop_n  = w_head_rvc ? 2'd1 : 2'd2;
      out_pc_d = out_pc_q + (w_head_rvc ? 32'd2 : 32'd4);
    end

    if (redirect) begin
      fetch_addr_d = redirect_pc[31:2];
`ifdef RVC_ALIGN_EN
      out_pc_d     = {redirect_pc[31:1], 1'b0};
      drop_low_d   = redirect_pc[1];
`else
      out_pc_d     = {redirect_pc[31:2], 2'b00};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_addr_q <= '0;
      out_pc_q     <= '0;
`ifdef RVC_ALIGN_EN
      drop_low_q   <= 1'b0;
`endif
    end else begin
      fetch_addr_q <= fetch_addr_d;
      out_pc_q     <= out_pc_d;
`ifdef RVC_ALIGN_EN
      drop_low_q   <= drop_low_d;
`endif
    end
  end

  align_hw_queue #(
    .HW_DEPTH (HW_DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (redirect),
    .push_n_i   (w_push_n),
    .push_hw0_i (w_push_hw0),
    .push_hw1_i (w_push_hw1),
    .pop_n_i    (w_pop_n),
    .peek_hw0_o (w_hw0),
    .peek_hw1_o (w_hw1),
    .count_o    (w_count)
  );

  assign fetch_addr = fetch_addr_q;
  assign out_pc     = out_pc_q;
  assign out_is_rvc = w_head_rvc;
  assign out_inst   = w_head_rvc ? {16'h0000, w_hw0} : {w_hw1, w_hw0};

endmodule
`default_nettype wire

// File: tb/tb_fetch_align_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_fetch_align_buffer                                            |
// | Purpose : Self-checking bench for fetch_align_buffer. A parcel-queue       |
// |           model tracks fetch address, PC and the expected instruction.     |
// |           Works with RVC_ALIGN_EN either defined or undefined.             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_fetch_align_buffer;
  import riscv_fetch_pkg::*;

  localparam int HW_DEPTH = 4;
`ifdef RVC_ALIGN_EN
  localparam bit c_RVC = 1'b1;
`else
  localparam bit c_RVC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [29:0] fetch_addr;
  logic        fetch_en;
  logic        fetch_stall;
  logic [31:0] fetch_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_is_rvc;

  always #5 clk = ~clk;

  fetch_align_buffer #(
    .HW_DEPTH (HW_DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_addr  (fetch_addr),
    .fetch_en    (fetch_en),
    .fetch_stall (fetch_stall),
    .fetch_data  (fetch_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .out_is_rvc  (out_is_rvc)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Instruction memory as the cache returns it (big-endian byte order).
  logic [31:0] imem [64];

  // Reference model: program-order parcels not yet consumed.
  logic [15:0] mq [$];
  logic [29:0] m_fa;
  logic [31:0] m_pc;
  logic        m_drop;

  function automatic logic [31:0] to_le(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs against the model, apply inputs, advance the
  // model, then wait for the next sampling point.
  task automatic step(input logic rd, input logic [31:0] rpc, input logic st, input logic rdy);
    logic        v, rvc, fe;
    logic [31:0] inst, le;
    int          n;
    fe   = (mq.size() <= HW_DEPTH - 2);
    v    = 1'b0;
    rvc  = c_RVC;
    inst = 32'h0;
    n    = 2;
    if (c_RVC && mq.size() >= 1) begin
      if (mq[0][1:0] != 2'b11) begin
        v = 1'b1; rvc = 1'b1; inst = {16'h0000, mq[0]}; n = 1;
      end
    end
    if (!v && mq.size() >= 2) begin
      v = 1'b1; rvc = 1'b0; inst = {mq[1], mq[0]}; n = 2;
    end

    chk("out_valid",  {31'b0, out_valid}, {31'b0, v});
    chk("fetch_en",   {31'b0, fetch_en},  {31'b0, fe});
    chk("fetch_addr", {2'b0, fetch_addr}, {2'b0, m_fa});
    chk("out_pc",     out_pc,             m_pc);
    if (v) begin
      chk("out_inst",   out_inst,              inst);
      chk("out_is_rvc", {31'b0, out_is_rvc},   {31'b0, rvc});
    end

    redirect    = rd;
    redirect_pc = rpc;
    fetch_stall = st;
    out_ready   = rdy;
    fetch_data  = st ? $urandom : imem[m_fa[5:0]];

    if (rd) begin
      mq.delete();
      m_fa   = rpc[31:2];
      m_pc   = c_RVC ? {rpc[31:1], 1'b0} : {rpc[31:2], 2'b00};
      m_drop = c_RVC & rpc[1];
    end else begin
      if (v && rdy) begin
        repeat (n) void'(mq.pop_front());
        m_pc = m_pc + 32'(2 * n);
      end
      if (fe && !st) begin
        le = to_le(fetch_data);
        if (!m_drop) mq.push_back(le[15:0]);
        mq.push_back(le[31:16]);
        m_drop = 1'b0;
        m_fa   = m_fa + 30'd1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    fetch_stall = 1'b1;
    out_ready   = 1'b0;
    fetch_data  = 32'h0;
    repeat (2) @(negedge clk);
    mq.delete();
    m_fa   = '0;
    m_pc   = '0;
    m_drop = 1'b0;
    chk("rst_out_valid", {31'b0, out_valid},  32'h0);
    chk("rst_out_inst",  out_inst,            32'h0);
    chk("rst_is_rvc",    {31'b0, out_is_rvc}, {31'b0, c_RVC});
    chk("rst_fetch_en",  {31'b0, fetch_en},   32'h1);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = $urandom;
    for (int i = 0; i < 8; i++)  imem[i] = to_le(NOP_INST);
    for (int i = 8; i < 12; i++) imem[i] = to_le(32'h4501_4501);
    imem[16] = to_le(32'h0013_4501);
    imem[17] = to_le(32'h1234_0000);

    // Reset and straight-line NOP stream.
    do_reset();
    repeat (10) step(1'b0, 32'h0, 1'b0, 1'b1);

    // Pairs of c.li in one word.
    step(1'b1, 32'h20, 1'b0, 1'b1);
    repeat (6) step(1'b0, 32'h0, 1'b0, 1'b1);

    // 32-bit instruction straddling a word boundary, second word held off.
    step(1'b1, 32'h40, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("straddle_gap", {31'b0, out_valid}, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    repeat (5) step(1'b0, 32'h0, 1'b0, 1'b1);

    // Redirect into the upper half of a word while the queue is full.
    step(1'b1, 32'h20, 1'b0, 1'b0);
    repeat (4) step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h102, 1'b0, 1'b1);
    chk("redir_fetch_addr", {2'b0, fetch_addr}, 32'h40);
    chk("redir_out_valid",  {31'b0, out_valid}, 32'h0);
    repeat (6) step(1'b0, 32'h0, 1'b0, 1'b1);

    // Back-pressure, release, then reset with a full queue.
    repeat (10) step(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (8)  step(1'b0, 32'h0, 1'b0, 1'b1);
    repeat (3)  step(1'b0, 32'h0, 1'b0, 1'b0);
    do_reset();

    // Random stalls, back-pressure and redirects.
    repeat (600) begin
      step(($urandom_range(0, 11) == 0), $urandom,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
